// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle cpu: reset hold, gated execution with
// optional single-step, retired-cycle counting, end-sentinel and budget timeout.
module cpu_run_ctrl #(
    parameter int unsigned RESET_CYCLES = 5,
    parameter int unsigned MAX_CYCLES   = 20,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter logic [31:0] END_SENTINEL = 32'h0000_006F
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 step_mode,
    input  logic                 step,
    input  logic [31:0]          instr,
    input  logic [31:0]          pc,
    output logic                 cpu_reset,
    output logic                 cpu_en,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [31:0]          halt_pc
);

    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET_HOLD,
        ST_RUN,
        ST_HALTED,
        ST_TIMEOUT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic              start_ok;
    logic              sentinel_hit;
    logic              budget_hit;

    // Sentinel outranks budget exhaustion when both land on the same edge.
    always_comb begin
        start_ok     = start && !abort &&
                       (state == ST_IDLE || state == ST_HALTED || state == ST_TIMEOUT);
        sentinel_hit = (state == ST_RUN) && cpu_en && (instr == END_SENTINEL);
        budget_hit   = (state == ST_RUN) && cpu_en && (instr != END_SENTINEL) &&
                       (cycle_count == CNT_WIDTH'(MAX_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                    if (start_ok) begin
                        state_next = ST_RESET_HOLD;
                    end
                end
                ST_RESET_HOLD: begin
                    if (hold_cnt == '0) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sentinel_hit) begin
                        state_next = ST_HALTED;
                    end else if (budget_hit) begin
                        state_next = ST_TIMEOUT;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // HALTED/TIMEOUT freeze the cpu without resetting it so its state stays inspectable.
    always_comb begin
        cpu_reset = (state == ST_IDLE) || (state == ST_RESET_HOLD);
        busy      = (state == ST_RESET_HOLD) || (state == ST_RUN);
        cpu_en    = (state == ST_RUN) && (!step_mode || step);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt    <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            halt_pc     <= '0;
        end else if (abort) begin
            done    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (start_ok) begin
                hold_cnt    <= HOLD_W'(RESET_CYCLES - 1);
                done        <= 1'b0;
                timeout     <= 1'b0;
                cycle_count <= '0;
            end
            if (state == ST_RESET_HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            if (sentinel_hit) begin
                done    <= 1'b1;
                halt_pc <= pc;
            end else if (budget_hit) begin
                timeout     <= 1'b1;
                halt_pc     <= pc;
                cycle_count <= CNT_WIDTH'(MAX_CYCLES);
            end else if (state == ST_RUN && cpu_en) begin
                cycle_count <= cycle_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: vector table, directed corner sequences and a
// randomized run, all compared against an abstract cycle model.
module tb_cpu_run_ctrl;

    localparam int unsigned RC   = 5;
    localparam int unsigned MAXC = 20;
    localparam int unsigned CW   = 32;
    localparam logic [31:0] SENT = 32'h0000_006F;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          reset, start, abort, step_mode, step;
    logic [31:0]   instr, pc;
    logic          cpu_reset, cpu_en, busy, done, timeout;
    logic [CW-1:0] cycle_count;
    logic [31:0]   halt_pc;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    cpu_run_ctrl #(
        .RESET_CYCLES(RC),
        .MAX_CYCLES  (MAXC),
        .CNT_WIDTH   (CW),
        .END_SENTINEL(SENT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .step_mode  (step_mode),
        .step       (step),
        .instr      (instr),
        .pc         (pc),
        .cpu_reset  (cpu_reset),
        .cpu_en     (cpu_en),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycle_count(cycle_count),
        .halt_pc    (halt_pc)
    );

    always #5 clk = ~clk;

    // Abstract model: hold_left counts remaining cpu-reset cycles, plus run/frozen flags.
    int          m_hold_left = 0;
    bit          m_run = 0, m_frozen = 0, m_done = 0, m_to = 0;
    int unsigned m_cnt = 0;
    logic [31:0] m_hpc = '0;

    function automatic bit m_en();
        return m_run && (!step_mode || step);
    endfunction

    task automatic model_edge();
        bit en;
        en = m_en();
        if (reset) begin
            m_hold_left = 0; m_run = 0; m_frozen = 0;
            m_done = 0; m_to = 0; m_cnt = 0; m_hpc = '0;
        end else if (abort) begin
            m_hold_left = 0; m_run = 0; m_frozen = 0; m_done = 0; m_to = 0;
        end else if (m_hold_left == 0 && !m_run) begin
            if (start) begin
                m_hold_left = RC; m_frozen = 0; m_done = 0; m_to = 0; m_cnt = 0;
            end
        end else if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) m_run = 1;
        end else if (en) begin
            if (instr == SENT) begin
                m_run = 0; m_frozen = 1; m_done = 1; m_hpc = pc;
            end else if (m_cnt + 1 == MAXC) begin
                m_run = 0; m_frozen = 1; m_to = 1; m_hpc = pc; m_cnt = MAXC;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic sample(input logic r, s, a, sm, st, input logic [31:0] ins, p);
        logic [6:0] act, exp;
        reset = r; start = s; abort = a; step_mode = sm; step = st; instr = ins; pc = p;
        @(negedge clk);
        act = {cpu_reset, cpu_en, busy, done, timeout, 2'b00};
        exp = {!(m_run || m_frozen), m_en(), (m_hold_left > 0) || m_run, m_done, m_to, 2'b00};
        tests++;
        if (act !== exp || cycle_count !== CW'(m_cnt) || halt_pc !== m_hpc) begin
            fails++;
            $display("FAIL model (cycle %0d): got rst/en/busy/done/to=%b cnt=%0d hpc=%0h expected %b cnt=%0d hpc=%0h",
                     cyc, act[6:2], cycle_count, halt_pc, exp[6:2], m_cnt, m_hpc);
        end
    endtask

    task automatic commit();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic tick(input logic r, s, a, sm, st, input logic [31:0] ins, p);
        sample(r, s, a, sm, st, ins, p);
        commit();
    endtask

    typedef struct {
        logic        start;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  e_flags;   // cpu_reset, cpu_en, busy, done, timeout
        logic [31:0] e_cnt;
        logic [31:0] e_hpc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [31:0] ins, p,
                                input logic [4:0] f, input logic [31:0] c, h);
        vec_t v;
        v.start = s; v.instr = ins; v.pc = p; v.e_flags = f; v.e_cnt = c; v.e_hpc = h;
        return v;
    endfunction

    vec_t vecs[12];
    int   n;
    int   en_seen;

    initial begin
        vecs[0]  = mk(1, NOP,  32'h00, 5'b10000, 0, 0);
        for (int i = 1; i <= 5; i++) vecs[i] = mk(0, NOP, 32'h00, 5'b10100, 0, 0);
        vecs[6]  = mk(0, NOP,  32'h00, 5'b01100, 0, 0);
        vecs[7]  = mk(0, NOP,  32'h04, 5'b01100, 1, 0);
        vecs[8]  = mk(0, NOP,  32'h08, 5'b01100, 2, 0);
        vecs[9]  = mk(0, SENT, 32'h0C, 5'b01100, 3, 0);
        vecs[10] = mk(0, NOP,  32'h10, 5'b00010, 3, 32'h0C);
        vecs[11] = mk(0, NOP,  32'h14, 5'b00010, 3, 32'h0C);

        reset = 1; start = 0; abort = 0; step_mode = 0; step = 0; instr = NOP; pc = '0;
        commit();
        tick(1, 0, 0, 0, 0, NOP, 0);
        tick(1, 0, 0, 0, 0, NOP, 0);

        // Normal run from the vector table.
        for (int i = 0; i < 12; i++) begin
            sample(0, vecs[i].start, 0, 0, 0, vecs[i].instr, vecs[i].pc);
            chk($sformatf("vec%0d_flags", i), 32'({cpu_reset, cpu_en, busy, done, timeout}),
                32'(vecs[i].e_flags));
            chk($sformatf("vec%0d_cnt", i), cycle_count, vecs[i].e_cnt);
            chk($sformatf("vec%0d_hpc", i), halt_pc, vecs[i].e_hpc);
            commit();
        end

        // Budget exhaustion.
        tick(0, 1, 0, 0, 0, NOP, 0);
        for (int i = 0; i < int'(RC); i++) tick(0, 0, 0, 0, 0, NOP, 0);
        for (int i = 0; i < int'(MAXC); i++) tick(0, 0, 0, 0, 0, NOP, 32'(i * 4));
        sample(0, 0, 0, 0, 0, NOP, 32'h100);
        chk("to_timeout", 32'(timeout), 1);
        chk("to_done", 32'(done), 0);
        chk("to_cnt", cycle_count, MAXC);
        chk("to_hpc", halt_pc, 32'h4C);
        chk("to_en", 32'(cpu_en), 0);
        commit();

        // Single step.
        tick(0, 1, 0, 1, 0, NOP, 0);
        for (int i = 0; i < int'(RC); i++) tick(0, 0, 0, 1, 0, NOP, 0);
        en_seen = 0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                sample(0, 0, 0, 1, (j == 0), NOP, 32'(k * 4));
                if (cpu_en) en_seen++;
                commit();
            end
        end
        chk("step_en_cycles", 32'(en_seen), 4);
        chk("step_cnt", cycle_count, 4);
        chk("step_busy", 32'(busy), 1);

        // Abort at count 7, start+abort collision, restart.
        tick(0, 0, 1, 0, 0, NOP, 0);
        tick(0, 1, 0, 0, 0, NOP, 0);
        for (int i = 0; i < int'(RC); i++) tick(0, 0, 0, 0, 0, NOP, 0);
        for (int i = 0; i < 7; i++) tick(0, 0, 0, 0, 0, NOP, 32'(i * 4));
        tick(0, 0, 1, 0, 0, NOP, 32'h1C);
        sample(0, 0, 0, 0, 0, NOP, 0);
        chk("abort_rst", 32'(cpu_reset), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_cnt", cycle_count, 7);
        chk("abort_flags", 32'({done, timeout}), 0);
        commit();
        tick(0, 1, 1, 0, 0, NOP, 0);
        chk("abort_wins", 32'(busy), 0);
        tick(0, 1, 0, 0, 0, NOP, 0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            sample(0, 0, 0, 0, 0, NOP, 0);
            if (!cpu_reset) break;
            n++;
            commit();
        end
        chk("restart_hold", 32'(n), RC);
        chk("restart_cnt", cycle_count, 0);
        commit();

        // Sentinel on the budget edge.
        tick(0, 0, 1, 0, 0, NOP, 0);
        tick(0, 1, 0, 0, 0, NOP, 0);
        for (int i = 0; i < int'(RC); i++) tick(0, 0, 0, 0, 0, NOP, 0);
        for (int i = 0; i < int'(MAXC) - 1; i++) tick(0, 0, 0, 0, 0, NOP, 32'(i * 4));
        tick(0, 0, 0, 0, 0, SENT, 32'h200);
        sample(0, 0, 0, 0, 0, NOP, 0);
        chk("coll_done", 32'(done), 1);
        chk("coll_to", 32'(timeout), 0);
        chk("coll_cnt", cycle_count, MAXC - 1);
        chk("coll_hpc", halt_pc, 32'h200);
        commit();

        // Ignored start while busy, then reset mid-run.
        tick(0, 1, 0, 0, 0, NOP, 0);
        for (int i = 0; i < int'(RC); i++) tick(0, 0, 0, 0, 0, NOP, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, NOP, 32'(i * 4));
        tick(0, 1, 0, 0, 0, NOP, 32'h0C);
        sample(0, 0, 0, 0, 0, NOP, 32'h10);
        chk("busy_start_cnt", cycle_count, 4);
        chk("busy_start_rst", 32'(cpu_reset), 0);
        commit();
        tick(1, 0, 0, 0, 0, NOP, 32'h14);
        sample(0, 0, 0, 0, 0, NOP, 0);
        chk("rst_flags", 32'({cpu_reset, cpu_en, busy, done, timeout}), 32'b10000);
        chk("rst_cnt", cycle_count, 0);
        chk("rst_hpc", halt_pc, 0);
        commit();

        // Randomized run against the model.
        begin
            logic sm;
            sm = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(29) == 0) sm = ~sm;
                tick($urandom_range(199) == 0, $urandom_range(7) == 0, $urandom_range(49) == 0,
                     sm, 1'($urandom), ($urandom_range(11) == 0) ? SENT : ($urandom | 32'h80),
                     $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run controller that sequences the single-cycle cpu for self-checking runs and board bring-up.
- Holds the cpu in reset for a programmed number of cycles, then releases it.
- Gates execution through a clock enable, with optional single-step.
- Counts retired cycles, detects the end sentinel (jal x0,0) and enforces a cycle-budget timeout.
- Sits between the test host/debug logic and the cpu's reset and enable inputs; observes the datapath's instr and pc_current.

Parameters:
RESET_CYCLES, 5, cycles cpu_reset is held after start; must be >= 1
MAX_CYCLES, 20, enabled-cycle budget before timeout; must be >= 1
CNT_WIDTH, 32, width of cycle_count; must hold MAX_CYCLES
END_SENTINEL, 32'h0000_006F, instruction word that ends a run

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high controller reset
start  in  1  begin a run; sampled only in IDLE, HALTED, TIMEOUT
abort  in  1  return to IDLE from any state; has priority over start
step_mode  in  1  1 = execute only on step pulses
step  in  1  in step_mode, enables exactly one cpu cycle per high cycle
instr  in  32  current instruction from datapath
pc  in  32  current pc from datapath
cpu_reset  out  1  reset to cpu
cpu_en  out  1  cpu clock enable (PC/regfile/dmem write qualify)
busy  out  1  high in RESET_HOLD and RUN
done  out  1  sticky: run ended on END_SENTINEL
timeout  out  1  sticky: run exhausted MAX_CYCLES
cycle_count  out  CNT_WIDTH  enabled non-sentinel cycles this run
halt_pc  out  32  pc captured at sentinel or timeout

Behaviour:
- Reset state:
  - state = IDLE.
  - cpu_reset = 1; cpu_en = 0; busy = 0; done = 0; timeout = 0; cycle_count = 0; halt_pc = 0.
- State outputs: cpu_reset and busy decode from state; cpu_en is combinational.
  - IDLE: cpu_reset = 1, cpu_en = 0.
  - RESET_HOLD: cpu_reset = 1, cpu_en = 0, busy = 1.
  - RUN: cpu_reset = 0, busy = 1, cpu_en = (!step_mode | step).
  - HALTED / TIMEOUT: cpu_reset = 0, cpu_en = 0. The cpu is frozen, not reset, so its state stays inspectable.
- IDLE / HALTED / TIMEOUT with start=1 and abort=0 at edge N:
  - go to RESET_HOLD; hold counter = RESET_CYCLES-1.
  - clear done, timeout, cycle_count; halt_pc unchanged.
- RESET_HOLD:
  - decrement the hold counter each edge; at 0 go to RUN.
  - cpu_reset is high for exactly RESET_CYCLES cycles after edge N and first low in the cycle after edge N+RESET_CYCLES.
- RUN, on each edge where cpu_en=1, checks in priority order:
  1. instr == END_SENTINEL → HALTED; done = 1; halt_pc = pc; cycle_count not incremented.
  2. cycle_count+1 == MAX_CYCLES → TIMEOUT; timeout = 1; halt_pc = pc; cycle_count = MAX_CYCLES.
  3. otherwise cycle_count += 1.
- RUN edges with cpu_en=0 (step_mode, no step): no state or count change.
- step_mode may change at any time; it takes effect combinationally in the same cycle.
- abort=1 at any edge:
  - go to IDLE; clear done and timeout.
  - keep cycle_count and halt_pc for post-mortem.
  - cpu_reset reasserts in the following cycle.
- start while busy: ignored. Simultaneous start+abort: abort wins.
- done and timeout are mutually exclusive and never both 1.
- Sentinel and budget exhaustion on the same edge: done wins.
- reset mid-run: all outputs take their reset values after that edge, with no partial completion.
- cycle_count never wraps: it saturates at MAX_CYCLES via the timeout state.

Test Plan:
1. Normal run:
   - Stimulus: reset for 2 cycles; start pulse at edge N; drive instr non-sentinel at pc 0x00, 0x04, 0x08, then 0x0000006F at pc 0x0C.
   - Response: cpu_reset high through edge N+5; cpu_en high 4 cycles; then done=1, busy=0, halt_pc=0x0C, cycle_count=3, timeout=0.
2. Timeout:
   - Stimulus: never present the sentinel, MAX_CYCLES=20.
   - Response: after the 20th enabled edge, timeout=1, done=0, cycle_count=20, halt_pc=pc of that cycle, cpu_en=0 thereafter.
3. Single step:
   - Stimulus: step_mode=1; 4 one-cycle step pulses separated by 3 idle cycles each.
   - Response: cpu_en high exactly 4 cycles, coincident with step; cycle_count=4; state stays RUN.
4. Abort and restart:
   - Stimulus: abort at cycle_count=7, then start again.
   - Response: IDLE with cpu_reset=1 the next cycle; cycle_count holds 7, done=timeout=0. Restart clears count to 0 and holds reset 5 cycles.
5. Collision:
   - Stimulus: sentinel on the edge where cycle_count=19 (MAX=20).
   - Response: done=1, timeout=0, cycle_count=19.
6. Reset mid-RUN and ignored start:
   - Stimulus: start pulse while busy; then reset in RUN.
   - Response: start has no effect; after the reset edge all outputs equal their reset values (cpu_reset=1, others 0).
